mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning cycles without ram_ack before a transaction is aborted (1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port inst_ren  input  1  instruction fetch request, held until inst_ack.
REQ-005 SHALL have port inst_addr  input  32  fetch address.
REQ-006 SHALL have port inst_data  output  32  fetched word, valid while inst_ack=1.
REQ-007 SHALL have port inst_ack  output  1  one-cycle completion pulse for fetch.
REQ-008 SHALL have port inst_stall  output  1  fetch pending: inst_ren & ~inst_ack.
REQ-009 SHALL have port mem_ren  input  1  data read request, held until mem_ack.
REQ-010 SHALL have port mem_wen  input  1  data write request, held until mem_ack.
REQ-011 SHALL have port mem_addr  input  32  data address.
REQ-012 SHALL have port mem_dout  input  32  store data.
REQ-013 SHALL have port mem_din  output  32  load data, valid while mem_ack=1.
REQ-014 SHALL have port mem_ack  output  1  one-cycle completion pulse for data access.
REQ-015 SHALL have port mem_stall  output  1  data access pending: (mem_ren|mem_wen) & ~mem_ack.
REQ-016 SHALL have ports ram_cs, ram_we  output  1  memory select and write strobe, held for the whole transaction.
REQ-017 SHALL have ports ram_addr, ram_wdata  output  32  registered address and write data.
REQ-018 SHALL have ports ram_ack  input  1, ram_rdata  input  32  memory completion pulse and read data.
REQ-019 SHALL have port bus_err  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement FSM states IDLE, INST, DATA, RESP.
REQ-021 In IDLE, a data request SHALL win over a simultaneous fetch: fixed priority, MEM stage is older.
REQ-022 IDLE->DATA or IDLE->INST SHALL register ram_addr/ram_we/ram_wdata and assert ram_cs from the next cycle.
REQ-023 mem_ren and mem_wen both high SHALL be treated as a write.
REQ-024 In INST/DATA, ram_ack SHALL capture ram_rdata, drop ram_cs and move to RESP.
REQ-025 RESP SHALL pulse exactly one of inst_ack/mem_ack with the captured data for one cycle, then return to IDLE.
REQ-026 Latency SHALL be request seen at cycle t, ram_cs at t+1, ram_ack at t+k, requester ack at t+k+1.
REQ-027 A write SHALL return mem_din = 0.
REQ-028 inst_data/mem_din SHALL hold their last value when not acked.
REQ-029 An 8-bit wait counter SHALL clear on entering INST/DATA and increment each cycle without ram_ack.
REQ-030 Counter reaching TIMEOUT SHALL abort: drop ram_cs, go to RESP, ack the requester with data 0, set bus_err.
REQ-031 ram_ack outside INST/DATA SHALL be ignored.
REQ-032 A request withdrawn before ack (pipeline flush) SHALL still complete; the ack SHALL be issued regardless.
REQ-033 At most one transaction SHALL be outstanding.
REQ-034 The next grant SHALL be evaluated no earlier than the IDLE cycle after RESP.

Reset
REQ-035 rst SHALL force IDLE, counter 0, ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0, inst_ack=0, mem_ack=0, inst_data=0, mem_din=0, bus_err=0.
REQ-036 rst mid-transaction SHALL abandon the transaction without an ack; a late ram_ack SHALL be ignored.

Structure
REQ-037 FSM state encodings and the timeout default SHALL live in shared package mem_arb_pkg.
REQ-038 No sub-module is required; FSM, counter and response registers SHALL reside in mem_port_arbiter.

Verification
REQ-039 Fetch alone: inst_addr=0x100, ram_ack two cycles after ram_cs with rdata 0x2002000A -> inst_ack one cycle later, inst_data=0x2002000A, inst_stall high until then.
REQ-040 Simultaneous inst_ren and mem_ren at cycle t -> data served first, mem_ack precedes inst_ack; fetch granted from the following IDLE.
REQ-041 Store: mem_wen with mem_addr=0x40, mem_dout=0xDEADBEEF -> ram_we=1, ram_wdata=0xDEADBEEF throughout, mem_ack with mem_din=0.
REQ-042 No ram_ack, TIMEOUT=4 -> abort after 4 wait cycles, ack with data 0, bus_err stays 1 until rst.
REQ-043 rst asserted while in DATA, then late ram_ack -> IDLE, no ack pulse, all outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM encoding, datapath widths and the default abort timeout.
package mem_arb_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Word returned to the requester: read data only for a completed read,
  // zero for writes and for aborted transactions.
  function automatic logic [DATA_W-1:0] resp_word(input logic          acked,
                                                  input logic          is_write,
                                                  input logic [DATA_W-1:0] rdata);
    return (acked && !is_write) ? rdata : '0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-outstanding
// RAM port; data accesses win ties, and a stalled RAM is aborted by a timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              inst_ren,
  input  logic [DATA_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_ack,
  output logic              inst_stall,
  // data load/store port
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ack,
  output logic              mem_stall,
  // RAM port
  output logic              ram_cs,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  // status
  output logic              bus_err
);

  arb_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ram_cs;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_inst_ack;
  logic              r_mem_ack;
  logic [DATA_W-1:0] r_inst_data;
  logic [DATA_W-1:0] r_mem_din;
  logic              r_bus_err;

  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_timeout;
  logic              w_done;
  logic [DATA_W-1:0] w_resp_data;

  // Abort on the wait cycle that would bring the counter up to TIMEOUT.
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_timeout   = (w_cnt_nxt == CNT_W'(TIMEOUT));
  assign w_done      = ram_ack | w_timeout;
  assign w_resp_data = resp_word(ram_ack, r_ram_we, ram_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_inst_ack  <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_inst_data <= '0;
      r_mem_din   <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_ren || mem_wen) begin
            r_state     <= DATA;
            r_cnt       <= '0;
            r_ram_cs    <= 1'b1;
            r_ram_we    <= mem_wen;
            r_ram_addr  <= mem_addr;
            r_ram_wdata <= mem_wen ? mem_dout : '0;
          end else if (inst_ren) begin
            r_state     <= INST;
            r_cnt       <= '0;
            r_ram_cs    <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= inst_addr;
            r_ram_wdata <= '0;
          end
        end
        INST, DATA: begin
          if (w_done) begin
            r_state  <= RESP;
            r_ram_cs <= 1'b0;
            r_ram_we <= 1'b0;
            if (r_state == DATA) begin
              r_mem_ack <= 1'b1;
              r_mem_din <= w_resp_data;
            end else begin
              r_inst_ack  <= 1'b1;
              r_inst_data <= w_resp_data;
            end
            if (!ram_ack) begin
              r_bus_err <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        RESP: begin
          // Ack pulse lasts exactly this cycle; grant re-evaluated in IDLE.
          r_inst_ack <= 1'b0;
          r_mem_ack  <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_cs     = r_ram_cs;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign inst_ack   = r_inst_ack;
  assign inst_data  = r_inst_data;
  assign mem_ack    = r_mem_ack;
  assign mem_din    = r_mem_din;
  assign bus_err    = r_bus_err;
  assign inst_stall = inst_ren & ~r_inst_ack;
  assign mem_stall  = (mem_ren | mem_wen) & ~r_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, arbitration, store, flush,
// timeout abort and mid-transaction reset with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_ack;
  logic        inst_stall;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_ack;
  logic        mem_stall;
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic        bus_err;

  int n_checks;
  int n_errors;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_ren  (inst_ren),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .inst_ack  (inst_ack),
    .inst_stall(inst_stall),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_ack   (mem_ack),
    .mem_stall (mem_stall),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_ack   (ram_ack),
    .ram_rdata (ram_rdata),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    inst_ren  = 1'b0;
    inst_addr = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    ram_ack   = 1'b0;
    ram_rdata = '0;
    step();
    step();

    // Reset state
    check("rst_cs",    {31'd0, ram_cs},   32'd0);
    check("rst_we",    {31'd0, ram_we},   32'd0);
    check("rst_addr",  ram_addr,          32'd0);
    check("rst_wdata", ram_wdata,         32'd0);
    check("rst_acks",  {30'd0, inst_ack, mem_ack}, 32'd0);
    check("rst_data",  inst_data | mem_din, 32'd0);
    check("rst_err",   {31'd0, bus_err},  32'd0);
    rst = 1'b0;
    step();

    // Fetch alone, ram_ack two cycles after ram_cs
    inst_ren  = 1'b1;
    inst_addr = 32'h0000_0100;
    #1;
    check("f_stall0", {31'd0, inst_stall}, 32'd1);
    step();
    check("f_cs",     {31'd0, ram_cs},     32'd1);
    check("f_addr",   ram_addr,            32'h0000_0100);
    check("f_we",     {31'd0, ram_we},     32'd0);
    step();
    check("f_cs2",    {31'd0, ram_cs},     32'd1);
    check("f_stall2", {31'd0, inst_stall}, 32'd1);
    check("f_noack",  {31'd0, inst_ack},   32'd0);
    step();
    ram_ack   = 1'b1;
    ram_rdata = 32'h2002_000A;
    step();
    ram_ack   = 1'b0;
    ram_rdata = 32'hFFFF_FFFF;
    check("f_ack",    {31'd0, inst_ack},   32'd1);
    check("f_data",   inst_data,           32'h2002_000A);
    check("f_stall3", {31'd0, inst_stall}, 32'd0);
    check("f_csoff",  {31'd0, ram_cs},     32'd0);
    check("f_memack", {31'd0, mem_ack},    32'd0);
    inst_ren = 1'b0;
    step();
    check("f_ackoff", {31'd0, inst_ack},   32'd0);
    check("f_hold",   inst_data,           32'h2002_000A);

    // Simultaneous fetch and load: data first
    inst_ren  = 1'b1;
    inst_addr = 32'h0000_0200;
    mem_ren   = 1'b1;
    mem_addr  = 32'h0000_0300;
    step();
    check("p_addr",   ram_addr,            32'h0000_0300);
    check("p_cs",     {31'd0, ram_cs},     32'd1);
    ram_ack   = 1'b1;
    ram_rdata = 32'h1111_2222;
    step();
    ram_ack = 1'b0;
    check("p_memack", {31'd0, mem_ack},    32'd1);
    check("p_din",    mem_din,             32'h1111_2222);
    check("p_noinst", {31'd0, inst_ack},   32'd0);
    mem_ren = 1'b0;
    step();
    check("p_idle_cs", {31'd0, ram_cs},    32'd0);
    step();
    check("p_ics",    {31'd0, ram_cs},     32'd1);
    check("p_iaddr",  ram_addr,            32'h0000_0200);
    ram_ack   = 1'b1;
    ram_rdata = 32'h3333_4444;
    step();
    ram_ack = 1'b0;
    check("p_instack", {31'd0, inst_ack},  32'd1);
    check("p_idata",  inst_data,           32'h3333_4444);
    check("p_dinhold", mem_din,            32'h1111_2222);
    inst_ren = 1'b0;
    step();

    // Store
    mem_wen  = 1'b1;
    mem_addr = 32'h0000_0040;
    mem_dout = 32'hDEAD_BEEF;
    step();
    check("s_we",     {31'd0, ram_we},     32'd1);
    check("s_wdata",  ram_wdata,           32'hDEAD_BEEF);
    check("s_addr",   ram_addr,            32'h0000_0040);
    check("s_stall",  {31'd0, mem_stall},  32'd1);
    step();
    check("s_we2",    {31'd0, ram_we},     32'd1);
    check("s_wdata2", ram_wdata,           32'hDEAD_BEEF);
    ram_ack   = 1'b1;
    ram_rdata = 32'hFFFF_FFFF;
    step();
    ram_ack = 1'b0;
    check("s_ack",    {31'd0, mem_ack},    32'd1);
    check("s_din",    mem_din,             32'd0);
    mem_wen = 1'b0;
    step();

    // Read and write both high behaves as a write
    mem_ren  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = 32'h0000_0044;
    mem_dout = 32'h1234_5678;
    step();
    check("rw_we",    {31'd0, ram_we},     32'd1);
    check("rw_wdata", ram_wdata,           32'h1234_5678);
    ram_ack   = 1'b1;
    ram_rdata = 32'h5555_AAAA;
    step();
    ram_ack = 1'b0;
    check("rw_din",   mem_din,             32'd0);
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    step();

    // Fetch withdrawn before ack still completes
    inst_ren  = 1'b1;
    inst_addr = 32'h0000_0500;
    step();
    check("w_cs",     {31'd0, ram_cs},     32'd1);
    inst_ren = 1'b0;
    step();
    ram_ack   = 1'b1;
    ram_rdata = 32'hCAFE_F00D;
    step();
    ram_ack = 1'b0;
    check("w_ack",    {31'd0, inst_ack},   32'd1);
    check("w_data",   inst_data,           32'hCAFE_F00D);
    step();

    // No ram_ack: abort after 4 wait cycles
    mem_ren  = 1'b1;
    mem_addr = 32'h0000_0080;
    step();
    check("t_cs1",    {31'd0, ram_cs},     32'd1);
    step();
    step();
    step();
    check("t_cs4",    {31'd0, ram_cs},     32'd1);
    check("t_err0",   {31'd0, bus_err},    32'd0);
    step();
    check("t_cs5",    {31'd0, ram_cs},     32'd0);
    check("t_ack",    {31'd0, mem_ack},    32'd1);
    check("t_din",    mem_din,             32'd0);
    check("t_err",    {31'd0, bus_err},    32'd1);
    mem_ren = 1'b0;
    step();
    step();
    step();
    check("t_sticky", {31'd0, bus_err},    32'd1);
    check("t_ackoff", {31'd0, mem_ack},    32'd0);

    // Reset mid-transaction, then a late ram_ack
    mem_ren  = 1'b1;
    mem_addr = 32'h0000_0090;
    step();
    check("r_cs",     {31'd0, ram_cs},     32'd1);
    rst = 1'b1;
    step();
    rst     = 1'b0;
    mem_ren = 1'b0;
    ram_ack = 1'b1;
    ram_rdata = 32'h7777_7777;
    step();
    ram_ack = 1'b0;
    check("r_cs0",    {31'd0, ram_cs},     32'd0);
    check("r_acks",   {30'd0, inst_ack, mem_ack}, 32'd0);
    check("r_err",    {31'd0, bus_err},    32'd0);
    check("r_addr",   ram_addr,            32'd0);
    check("r_idata",  inst_data,           32'd0);
    check("r_din",    mem_din,             32'd0);
    step();
    check("r_acks2",  {30'd0, inst_ack, mem_ack}, 32'd0);
    check("r_cs2",    {31'd0, ram_cs},     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
